// File: rtl/controlador_memoria_instrucoes.sv
// Instruction memory controller: loads a program word by word into an external
// array, then serves CPU fetches until a HALT instruction or a reload request.
module controlador_memoria_instrucoes #(
    parameter int ADDR_W = 26,
    parameter int DEPTH  = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [31:0]       load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              recarregar,
    input  logic [ADDR_W-1:0] pc,
    input  logic              fetch_req,
    output logic [31:0]       instrucao,
    output logic              fetch_valid,
    output logic              cpu_stall,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] load_count,
    output logic              erro
);

    typedef enum logic [1:0] {CARGA, EXEC, PARADO, ERRO} estado_t;

    localparam logic [5:0]        OP_HALT = 6'b111110;
    localparam logic [ADDR_W-1:0] ULTIMO  = ADDR_W'(DEPTH - 1);

    estado_t           estado;
    logic [ADDR_W-1:0] wptr;
    logic              handshake;
    logic              halt_visto;

    // Reset gates the strobe so a word offered in the reset cycle never lands.
    assign handshake  = (estado == CARGA) && load_valid && load_ready && !reset;
    assign mem_we     = handshake;
    assign mem_addr   = (estado == CARGA) ? wptr : pc;
    assign mem_wdata  = handshake ? load_data : '0;
    assign halt_visto = fetch_valid && (instrucao[31:26] == OP_HALT);

    always_ff @(posedge clock) begin
        if (reset) begin
            estado      <= CARGA;
            wptr        <= '0;
            load_count  <= '0;
            erro        <= 1'b0;
            instrucao   <= '0;
            fetch_valid <= 1'b0;
            load_ready  <= 1'b1;
            cpu_stall   <= 1'b1;
        end else begin
            fetch_valid <= 1'b0;
            if (estado != CARGA && recarregar) begin
                estado     <= CARGA;
                wptr       <= '0;
                load_count <= '0;
                erro       <= 1'b0;
                load_ready <= 1'b1;
                cpu_stall  <= 1'b1;
            end else begin
                case (estado)
                    CARGA: begin
                        if (handshake) begin
                            load_count <= load_count + ADDR_W'(1);
                            if (wptr != ULTIMO)
                                wptr <= wptr + ADDR_W'(1);
                            if (load_last) begin
                                estado     <= EXEC;
                                load_ready <= 1'b0;
                                cpu_stall  <= 1'b0;
                            end else if (wptr == ULTIMO) begin
                                estado     <= ERRO;
                                erro       <= 1'b1;
                                load_ready <= 1'b0;
                            end
                        end
                    end
                    EXEC: begin
                        // A fetch issued while HALT is being returned is dropped; instrucao keeps HALT.
                        if (halt_visto) begin
                            estado    <= PARADO;
                            cpu_stall <= 1'b1;
                        end else if (fetch_req) begin
                            fetch_valid <= 1'b1;
                            instrucao   <= (pc < load_count) ? mem_rdata : '0;
                        end
                    end
                    PARADO, ERRO: ;
                    default: estado <= CARGA;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_controlador_memoria_instrucoes.sv
// Scoreboard bench for controlador_memoria_instrucoes: a behavioural model predicts
// memory writes and fetch results; a negedge monitor compares them against the DUT.
module tb_controlador_memoria_instrucoes;

    localparam int ADDR_W = 26;
    localparam int DEPTH  = 64;
    localparam int AW     = $clog2(DEPTH);
    localparam logic [5:0] OP_HALT = 6'b111110;

    logic              clock = 1'b0;
    logic              reset;
    logic              load_valid;
    logic [31:0]       load_data;
    logic              load_last;
    logic              load_ready;
    logic              recarregar;
    logic [ADDR_W-1:0] pc;
    logic              fetch_req;
    logic [31:0]       instrucao;
    logic              fetch_valid;
    logic              cpu_stall;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic [ADDR_W-1:0] load_count;
    logic              erro;

    always #5 clock = ~clock;

    controlador_memoria_instrucoes #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .recarregar(recarregar),
        .pc(pc), .fetch_req(fetch_req), .instrucao(instrucao),
        .fetch_valid(fetch_valid), .cpu_stall(cpu_stall),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .load_count(load_count), .erro(erro)
    );

    // Instruction array the controller drives (environment, not the reference).
    logic [31:0] mem_arr [DEPTH];
    always @(posedge clock) if (mem_we) mem_arr[mem_addr[AW-1:0]] <= mem_wdata;
    assign mem_rdata = (mem_addr < ADDR_W'(DEPTH)) ? mem_arr[mem_addr[AW-1:0]] : 32'hDEAD_BEEF;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference model
    typedef enum {M_LOAD, M_RUN, M_HALTED, M_ERR} mode_t;
    typedef struct { int due; logic [ADDR_W-1:0] addr; logic [31:0] data; } wr_t;
    typedef struct { int due; logic [31:0] data; } ft_t;

    wr_t wq [$];
    ft_t fq [$];
    mode_t       m_mode = M_LOAD;
    int          m_cnt  = 0;
    bit          m_err  = 1'b0;
    bit          m_halt_pend = 1'b0;
    logic [31:0] m_instr = '0;
    logic [31:0] m_mem [DEPTH];

    task automatic model_step(bit rst, bit lv, logic [31:0] ld, bit ll, bit rc,
                              logic [ADDR_W-1:0] p, bit fr);
        bit pend;
        logic [31:0] r;
        pend = m_halt_pend;
        m_halt_pend = 1'b0;
        if (rst) begin
            m_mode = M_LOAD; m_cnt = 0; m_err = 1'b0; m_instr = '0;
            return;
        end
        if (m_mode != M_LOAD && rc) begin
            m_mode = M_LOAD; m_cnt = 0; m_err = 1'b0;
            return;
        end
        case (m_mode)
            M_LOAD: if (lv) begin
                wq.push_back('{cyc, ADDR_W'(m_cnt), ld});
                m_mem[m_cnt] = ld;
                m_cnt++;
                if (ll) m_mode = M_RUN;
                else if (m_cnt == DEPTH) begin m_mode = M_ERR; m_err = 1'b1; end
            end
            M_RUN: if (pend) m_mode = M_HALTED;
                else if (fr) begin
                    r = (int'(p) < m_cnt) ? m_mem[p[AW-1:0]] : 32'h0;
                    fq.push_back('{cyc + 1, r});
                    m_instr = r;
                    if (r[31:26] == OP_HALT) m_halt_pend = 1'b1;
                end
            default: ;
        endcase
    endtask

    // Monitor: every cycle, the DUT must present exactly what the model scheduled.
    wr_t w;
    ft_t f;
    always @(negedge clock) if (mon_en) begin
        if (wq.size() > 0 && wq[0].due == cyc) begin
            w = wq.pop_front();
            check("mem_we", 64'(mem_we), 64'(1));
            check("mem_addr", 64'(mem_addr), 64'(w.addr));
            check("mem_wdata", 64'(mem_wdata), 64'(w.data));
        end else
            check("mem_we_idle", 64'(mem_we), 64'(0));
        if (fq.size() > 0 && fq[0].due == cyc) begin
            f = fq.pop_front();
            check("fetch_valid", 64'(fetch_valid), 64'(1));
            check("instrucao", 64'(instrucao), 64'(f.data));
        end else
            check("fetch_valid_idle", 64'(fetch_valid), 64'(0));
    end

    task automatic cycle(bit rst, bit lv, logic [31:0] ld, bit ll, bit rc,
                         logic [ADDR_W-1:0] p, bit fr);
        mode_t pre;
        pre = m_mode;
        reset = rst; load_valid = lv; load_data = ld; load_last = ll;
        recarregar = rc; pc = p; fetch_req = fr;
        model_step(rst, lv, ld, ll, rc, p, fr);
        #1;
        if (mon_en && !rst && pre != M_LOAD) check("mem_addr_pc", 64'(mem_addr), 64'(p));
        @(posedge clock); #1;
        check("load_count", 64'(load_count), 64'(m_cnt));
        check("erro", 64'(erro), 64'(m_err));
        check("load_ready", 64'(load_ready), 64'(m_mode == M_LOAD));
        check("cpu_stall", 64'(cpu_stall), 64'(m_mode != M_RUN));
        check("instrucao_hold", 64'(instrucao), 64'(m_instr));
    endtask

    task automatic idle(logic [ADDR_W-1:0] p, bit fr);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, p, fr);
    endtask

    function automatic logic [31:0] rand_word(bit want_halt);
        logic [31:0] v;
        v = $urandom;
        if (want_halt) v[31:26] = OP_HALT;
        else if (v[31:26] == OP_HALT) v[31] = 1'b0;
        return v;
    endfunction

    logic [31:0] prog [8];

    initial begin
        prog = '{32'h0C010000, 32'h10010000, 32'h0C020000, 32'h10020000,
                 32'h00221820, 32'h14011800, 32'h08000000, 32'hF8000000};
        reset = 1'b1; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        recarregar = 1'b0; pc = '0; fetch_req = 1'b0;
        @(posedge clock); #1;
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        mon_en = 1'b1;
        check("reset_mem_addr", 64'(mem_addr), 64'(0));
        check("reset_mem_wdata", 64'(mem_wdata), 64'(0));
        check("reset_fetch_valid", 64'(fetch_valid), 64'(0));

        // Eight-word program with idle gaps, load_last on the final word.
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 2)) idle('0, 1'b0);
            cycle(1'b0, 1'b1, prog[i], i == 7, 1'b0, '0, 1'b0);
        end
        check("exec_after_load", 64'(cpu_stall), 64'(0));
        idle(26'd5, 1'b1);
        idle(26'd5, 1'b0);
        idle(26'd20, 1'b1);
        for (int i = 0; i < 20; i++) begin
            int p;
            p = $urandom_range(0, 30);
            if (p == 7) p = 6;
            idle(ADDR_W'(p), 1'($urandom_range(0, 1)));
        end
        idle(26'd7, 1'b1);
        repeat (3) idle(26'd3, 1'b1);
        check("parado_stall", 64'(cpu_stall), 64'(1));

        // Overflow: DEPTH words without load_last, then one more offer.
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, '0, 1'b0);
        for (int i = 0; i < DEPTH + 1; i++)
            cycle(1'b0, 1'b1, rand_word(1'b0), 1'b0, 1'b0, '0, 1'b0);
        check("overflow_erro", 64'(erro), 64'(1));
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, '0, 1'b0);

        // Reset during the third handshake, then reload and fetch together.
        cycle(1'b0, 1'b1, prog[0], 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b1, prog[1], 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b1, prog[2], 1'b0, 1'b0, '0, 1'b0);
        check("reset_mid_load", 64'(load_count), 64'(0));
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b1, prog[i], i == 3, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, 26'd1, 1'b1);
        idle('0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit rst, lv, ll, rc, fr;
            rst = ($urandom_range(0, 199) == 0);
            rc  = ($urandom_range(0, 39) == 0);
            lv  = 1'($urandom_range(0, 1));
            ll  = ($urandom_range(0, 9) == 0);
            fr  = 1'($urandom_range(0, 1));
            cycle(rst, lv, rand_word($urandom_range(0, 7) == 0), ll, rc,
                  ADDR_W'($urandom_range(0, 40)), fr);
        end
        idle('0, 1'b0);
        idle('0, 1'b0);
        check("write_queue_drained", 64'(wq.size()), 64'(0));
        check("fetch_queue_drained", 64'(fq.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
